// File: rtl/cmd_icd_pkg.sv
// Command word layout shared by the builder and its consumers: the encoder and
// decoders live side by side so the field positions cannot drift apart.
package cmd_icd_pkg;

  typedef enum logic [3:0] {
    CMD_ID_NOP = 4'h0,
    CMD_ID_OUT = 4'h1
  } cmd_id_t;

  localparam int CMD_ID_MSB   = 31;
  localparam int CMD_ID_LSB   = 28;
  localparam int CMD_RSVD_MSB = 27;
  localparam int CMD_RSVD_LSB = 5;
  localparam int CMD_OUT_W    = 5;

  function automatic logic [31:0] task2out_cmd(input logic [CMD_OUT_W-1:0] value);
    return {CMD_ID_OUT, 23'd0, value};
  endfunction

  function automatic cmd_id_t cmd_id_of(input logic [31:0] word);
    return cmd_id_t'(word[CMD_ID_MSB:CMD_ID_LSB]);
  endfunction

  // Any ID other than OUT, or any reserved bit set, makes the word unusable.
  function automatic logic cmd_is_valid_out(input logic [31:0] word);
    return (cmd_id_of(word) == CMD_ID_OUT) &&
           (word[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0);
  endfunction

endpackage

// File: rtl/cmd_out_exec.sv
// Executes OUT command words: captures, decodes, updates a paced 5-bit output.
// Optional error counter port enabled by defining CMD_OUT_EXEC_ERR_CNT_EN.
module cmd_out_exec
  import cmd_icd_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_data,
  output logic [CMD_OUT_W-1:0] out,
  output logic                 out_strobe,
  output logic                 err_pulse,
  output logic                 busy
`ifdef CMD_OUT_EXEC_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    HOLD
  } exec_state_t;

  exec_state_t          state_reg, state_next;
  logic [31:0]          cmd_reg, cmd_next;
  logic [CMD_OUT_W-1:0] out_reg, out_next;
  logic                 strobe_reg, strobe_next;
  logic                 err_reg, err_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cmd_reg    <= '0;
      out_reg    <= '0;
      strobe_reg <= 1'b0;
      err_reg    <= 1'b0;
      hold_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cmd_reg    <= cmd_next;
      out_reg    <= out_next;
      strobe_reg <= strobe_next;
      err_reg    <= err_next;
      hold_reg   <= hold_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    out_next    = out_reg;
    strobe_next = 1'b0;
    err_next    = 1'b0;
    hold_next   = hold_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          cmd_next   = cmd_data;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (cmd_is_valid_out(cmd_reg)) begin
          out_next    = cmd_reg[CMD_OUT_W-1:0];
          strobe_next = 1'b1;
          hold_next   = HOLD_W'(HOLD_CYCLES - 1);
          state_next  = HOLD;
        end else begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (hold_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst_n keeps ready low for the whole time reset is held.
  assign cmd_ready  = (state_reg == IDLE) && rst_n;
  assign busy       = (state_reg != IDLE);
  assign out        = out_reg;
  assign out_strobe = strobe_reg;
  assign err_pulse  = err_reg;

`ifdef CMD_OUT_EXEC_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (err_reg && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_cmd_out_exec.sv
// Directed self-checking bench for cmd_out_exec; samples outputs on the falling edge.
module tb_cmd_out_exec;
  import cmd_icd_pkg::*;

  localparam int HC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [4:0]  out;
  logic        out_strobe;
  logic        err_pulse;
  logic        busy;
`ifdef CMD_OUT_EXEC_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cmd_out_exec #(.HOLD_CYCLES(HC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .out        (out),
    .out_strobe (out_strobe),
    .err_pulse  (err_pulse),
    .busy       (busy)
`ifdef CMD_OUT_EXEC_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Returns on the falling edge just after the transfer (DECODE cycle).
  task automatic send(input logic [31:0] w);
    wait_ready();
    cmd_data  = w;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("xfer data=%h", w);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_out", {27'd0, out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobe", {31'd0, out_strobe}, 32'd0);
    check("rst_err", {31'd0, err_pulse}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Single OUT word: ready low HC+1 cycles, strobe one cycle after transfer.
    check("builder", task2out_cmd(5'h15), 32'h1000_0015);
    send(32'h1000_0015);
    for (int j = 0; j <= HC; j++) begin
      check($sformatf("t1_ready_j%0d", j), {31'd0, cmd_ready}, 32'd0);
      check($sformatf("t1_strobe_j%0d", j), {31'd0, out_strobe}, {31'd0, (j == 1)});
      check($sformatf("t1_out_j%0d", j), {27'd0, out}, (j == 0) ? 32'h0 : 32'h15);
      @(negedge clk);
    end
    check("t1_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("t1_strobe_done", {31'd0, out_strobe}, 32'd0);
    check("t1_busy_done", {31'd0, busy}, 32'd0);

    // Back-to-back with cmd_valid held high.
    send(32'h1000_0003);
    cmd_valid = 1'b1;
    cmd_data  = 32'h1000_001F;
    for (int j = 0; j <= HC + 1; j++) begin
      check($sformatf("b2b_ready_j%0d", j), {31'd0, cmd_ready}, {31'd0, (j == HC + 1)});
      check($sformatf("b2b_strobe_j%0d", j), {31'd0, out_strobe}, {31'd0, (j == 1)});
      check($sformatf("b2b_out_j%0d", j), {27'd0, out}, (j == 0) ? 32'h15 : 32'h03);
      if (j < HC + 1) @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("xfer data=%h", 32'h1000_001F);
    check("b2b_dec_ready", {31'd0, cmd_ready}, 32'd0);
    check("b2b_dec_out", {27'd0, out}, 32'h03);
    @(negedge clk);
    check("b2b_out2", {27'd0, out}, 32'h1F);
    check("b2b_strobe2", {31'd0, out_strobe}, 32'd1);

    // Unknown ID, then reserved bit set: both rejected in 2 cycles.
    send(32'h2000_0007);
    check("badid_dec_err", {31'd0, err_pulse}, 32'd0);
    check("badid_dec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("badid_err", {31'd0, err_pulse}, 32'd1);
    check("badid_out", {27'd0, out}, 32'h1F);
    check("badid_strobe", {31'd0, out_strobe}, 32'd0);
    check("badid_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("badid_err_off", {31'd0, err_pulse}, 32'd0);

    send(32'h1000_0107);
    check("rsvd_dec_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("rsvd_err", {31'd0, err_pulse}, 32'd1);
    check("rsvd_out", {27'd0, out}, 32'h1F);
    check("rsvd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("rsvd_err_off", {31'd0, err_pulse}, 32'd0);
`ifdef CMD_OUT_EXEC_ERR_CNT_EN
    check("errcnt_two", {24'd0, err_cnt}, 32'd2);
`endif

    // Reset two cycles into HOLD.
    send(32'h1000_000A);
    @(negedge clk);
    check("rsthold_out_a", {27'd0, out}, 32'h0A);
    @(negedge clk);
    check("rsthold_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsthold_out", {27'd0, out}, 32'h0);
    check("rsthold_busy", {31'd0, busy}, 32'd0);
    check("rsthold_ready", {31'd0, cmd_ready}, 32'd0);
    check("rsthold_strobe", {31'd0, out_strobe}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("rel_strobe_j%0d", j), {31'd0, out_strobe}, 32'd0);
      check($sformatf("rel_ready_j%0d", j), {31'd0, cmd_ready}, 32'd1);
      check($sformatf("rel_out_j%0d", j), {27'd0, out}, 32'h0);
    end
`ifdef CMD_OUT_EXEC_ERR_CNT_EN
    check("errcnt_rst1", {24'd0, err_cnt}, 32'd0);
`endif

    // Same value twice still strobes twice.
    send(32'h1000_0015);
    @(negedge clk);
    check("rep1_out", {27'd0, out}, 32'h15);
    check("rep1_strobe", {31'd0, out_strobe}, 32'd1);
    send(32'h1000_0015);
    check("rep2_dec_out", {27'd0, out}, 32'h15);
    check("rep2_dec_strobe", {31'd0, out_strobe}, 32'd0);
    @(negedge clk);
    check("rep2_out", {27'd0, out}, 32'h15);
    check("rep2_strobe", {31'd0, out_strobe}, 32'd1);
    wait_ready();

`ifdef CMD_OUT_EXEC_ERR_CNT_EN
    for (int i = 0; i < 260; i++) send(32'h2000_0007);
    wait_ready();
    repeat (2) @(negedge clk);
    check("errcnt_sat", {24'd0, err_cnt}, 32'hFF);
    rst_n = 1'b0;
    #1;
    check("errcnt_rst2", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
